// File: rtl/ex_mem_skid.sv
// rtl/ex_mem_skid.sv - EX/MEM pipeline register with a two-entry skid buffer.
// Optional forwarding tap enabled by defining EX_MEM_FWD_BYPASS_EN.
module ex_mem_skid #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_result,
    input  logic [XLEN-1:0] in_store_data,
    input  logic [4:0]      in_rd,
    input  logic            in_reg_write,
    input  logic            in_mem_read,
    input  logic            in_mem_write,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [XLEN-1:0] out_store_data,
    output logic [4:0]      out_rd,
    output logic            out_reg_write,
    output logic            out_mem_read,
    output logic            out_mem_write
`ifdef EX_MEM_FWD_BYPASS_EN
    ,
    output logic            fwd_valid,
    output logic [4:0]      fwd_rd,
    output logic [XLEN-1:0] fwd_result
`endif
);

    // Entry layout: {rd, reg_write, mem_read, mem_write, store_data, result}
    localparam int EW = 2 * XLEN + 8;

    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b01;
    localparam logic [1:0] ST_FULL  = 2'b10;

    logic [1:0]    r_state;
    logic          r_main_valid;
    logic          r_skid_valid;
    logic [EW-1:0] r_main;
    logic [EW-1:0] r_skid;

    logic [EW-1:0] w_in;
    logic          w_accept;
    logic          w_consume;
    logic [1:0]    w_state_nxt;
    logic          w_main_load;
    logic          w_main_from_skid;
    logic          w_skid_load;

    assign w_in = {in_rd, in_reg_write, in_mem_read, in_mem_write, in_store_data, in_result};

    // in_ready depends only on registers so out_ready never ripples upstream
    assign in_ready  = (r_state != ST_FULL) & ~r_skid_valid;
    assign out_valid = r_main_valid;
    assign w_accept  = in_valid & in_ready;
    assign w_consume = out_valid & out_ready;

    always_comb begin
        w_state_nxt      = r_state;
        w_main_load      = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_load      = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_main_load = 1'b1;
                    w_state_nxt = ST_ONE;
                end
            end
            ST_ONE: begin
                if (w_accept && w_consume) begin
                    w_main_load = 1'b1;
                end else if (w_accept) begin
                    w_skid_load = 1'b1;
                    w_state_nxt = ST_FULL;
                end else if (w_consume) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_consume) begin
                    w_main_from_skid = 1'b1;
                    w_state_nxt      = ST_ONE;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_EMPTY;
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_main       <= '0;
            r_skid       <= '0;
        end else if (flush) begin
            r_state      <= ST_EMPTY;
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_main_valid <= (w_state_nxt != ST_EMPTY);
            r_skid_valid <= (w_state_nxt == ST_FULL);
            if (w_main_load) begin
                r_main <= w_in;
            end else if (w_main_from_skid) begin
                r_main <= r_skid;
            end
            if (w_skid_load) begin
                r_skid <= w_in;
            end
        end
    end

    assign out_result     = r_main[XLEN-1:0];
    assign out_store_data = r_main[2*XLEN-1:XLEN];
    assign out_mem_write  = r_main_valid & r_main[2*XLEN];
    assign out_mem_read   = r_main_valid & r_main[2*XLEN+1];
    assign out_reg_write  = r_main_valid & r_main[2*XLEN+2];
    assign out_rd         = r_main[2*XLEN+7:2*XLEN+3];

`ifdef EX_MEM_FWD_BYPASS_EN
    // x0 is hardwired zero, so it never forwards
    assign fwd_valid  = out_valid & out_reg_write & (out_rd != 5'd0);
    assign fwd_rd     = out_rd;
    assign fwd_result = out_result;
`endif

endmodule

// File: tb/tb_ex_mem_skid.sv
// tb/tb_ex_mem_skid.sv - directed self-checking bench for ex_mem_skid.
module tb_ex_mem_skid;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic [31:0] in_store_data;
    logic [4:0]  in_rd;
    logic        in_reg_write;
    logic        in_mem_read;
    logic        in_mem_write;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [31:0] out_store_data;
    logic [4:0]  out_rd;
    logic        out_reg_write;
    logic        out_mem_read;
    logic        out_mem_write;
`ifdef EX_MEM_FWD_BYPASS_EN
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_result;
`endif

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    ex_mem_skid #(.XLEN(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_result     (in_result),
        .in_store_data (in_store_data),
        .in_rd         (in_rd),
        .in_reg_write  (in_reg_write),
        .in_mem_read   (in_mem_read),
        .in_mem_write  (in_mem_write),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_store_data(out_store_data),
        .out_rd        (out_rd),
        .out_reg_write (out_reg_write),
        .out_mem_read  (out_mem_read),
        .out_mem_write (out_mem_write)
`ifdef EX_MEM_FWD_BYPASS_EN
        ,
        .fwd_valid     (fwd_valid),
        .fwd_rd        (fwd_rd),
        .fwd_result    (fwd_result)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] res, input logic [31:0] sd,
                         input logic [4:0] rd, input logic rw, input logic mr, input logic mw);
        in_valid      = v;
        in_result     = res;
        in_store_data = sd;
        in_rd         = rd;
        in_reg_write  = rw;
        in_mem_read   = mr;
        in_mem_write  = mw;
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_result", out_result, 32'h0);
        chk("rst_out_rd", 32'(out_rd), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // single push, immediately consumed
        out_ready = 1'b1;
        drive(1'b1, 32'h0000_00F0, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0);
        tick();
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_result", out_result, 32'h0000_00F0);
        chk("single_rd", 32'(out_rd), 32'd5);
        chk("single_rw", 32'(out_reg_write), 32'd1);
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("single_empty", 32'(out_valid), 32'd0);
        chk("single_rw_forced0", 32'(out_reg_write), 32'd0);

        // backpressure: fill to FULL, third push stalls
        out_ready = 1'b0;
        drive(1'b1, 32'h1, 32'hAAAA, 5'd1, 1'b0, 1'b1, 1'b0);
        tick();
        chk("bp_a_result", out_result, 32'h1);
        chk("bp_a_store", out_store_data, 32'hAAAA);
        chk("bp_a_mr", 32'(out_mem_read), 32'd1);
        chk("bp_ready_one", 32'(in_ready), 32'd1);
        drive(1'b1, 32'h2, 32'hBBBB, 5'd2, 1'b0, 1'b0, 1'b1);
        tick();
        chk("bp_full_ready", 32'(in_ready), 32'd0);
        chk("bp_full_result", out_result, 32'h1);
        drive(1'b1, 32'h3, 32'hCCCC, 5'd3, 1'b1, 1'b0, 1'b0);
        tick();
        chk("bp_stall_ready", 32'(in_ready), 32'd0);
        chk("bp_stall_result", out_result, 32'h1);
        chk("bp_stall_valid", 32'(out_valid), 32'd1);
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b1;
        chk("bp_drain_first", out_result, 32'h1);
        tick();
        chk("bp_drain_second", out_result, 32'h2);
        chk("bp_b_mw", 32'(out_mem_write), 32'd1);
        chk("bp_b_mr", 32'(out_mem_read), 32'd0);
        chk("bp_b_store", out_store_data, 32'hBBBB);
        chk("bp_b_ready", 32'(in_ready), 32'd1);
        tick();
        chk("bp_no_third", 32'(out_valid), 32'd0);

        // full-rate streaming
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'h10 + 32'(i), 32'h0, 5'd4, 1'b1, 1'b0, 1'b0);
            chk("stream_ready", 32'(in_ready), 32'd1);
            tick();
            chk("stream_valid", 32'(out_valid), 32'd1);
            chk("stream_result", out_result, 32'h10 + 32'(i));
        end
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("stream_empty", 32'(out_valid), 32'd0);

        // flush from FULL with a push pending
        out_ready = 1'b0;
        drive(1'b1, 32'h21, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h22, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0);
        tick();
        chk("fl_full_ready", 32'(in_ready), 32'd0);
        flush = 1'b1;
        drive(1'b1, 32'h99, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0);
        tick();
        chk("fl_valid", 32'(out_valid), 32'd0);
        chk("fl_ready", 32'(in_ready), 32'd1);
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("fl_not_captured", 32'(out_valid), 32'd0);

        // flush in ONE overrides a simultaneous accept
        drive(1'b1, 32'h31, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0);
        tick();
        flush = 1'b1;
        drive(1'b1, 32'h32, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0);
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("fl_one_valid", 32'(out_valid), 32'd0);
        tick();
        chk("fl_one_stay", 32'(out_valid), 32'd0);

        // asynchronous reset between edges while FULL
        drive(1'b1, 32'h41, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h42, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("ar_full", 32'(in_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(out_valid), 32'd0);
        chk("ar_ready", 32'(in_ready), 32'd1);
        chk("ar_result", out_result, 32'h0);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("ar_no_stale", 32'(out_valid), 32'd0);
        drive(1'b1, 32'h43, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0);
        tick();
        chk("ar_empty_latency", out_result, 32'h43);
        chk("ar_empty_valid", 32'(out_valid), 32'd1);
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();

`ifdef EX_MEM_FWD_BYPASS_EN
        out_ready = 1'b0;
        drive(1'b1, 32'h55, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0);
        tick();
        chk("fwd_rd0_valid", 32'(fwd_valid), 32'd0);
        flush = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        flush = 1'b0;
        drive(1'b1, 32'hDEAD_BEEF, 32'h0, 5'd7, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("fwd_valid", 32'(fwd_valid), 32'd1);
        chk("fwd_rd", 32'(fwd_rd), 32'd7);
        chk("fwd_result", fwd_result, 32'hDEAD_BEEF);
        out_ready = 1'b1;
        tick();
        chk("fwd_gone", 32'(fwd_valid), 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ex_mem_skid.md
EX_MEM_SKID -- requirements
Module: ex_mem_skid

Interface
REQ-001 SHALL have parameter: XLEN, 32, datapath width of result and store data.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: flush  input  1  synchronous kill of all held entries.
REQ-005 SHALL have port: in_valid  input  1  execute-stage (ALU/shifter) result valid.
REQ-006 SHALL have port: in_ready  output  1  buffer can accept this cycle.
REQ-007 SHALL have ports: in_result  input  XLEN  ALU/shift result; in_store_data  input  XLEN  store operand.
REQ-008 SHALL have ports: in_rd  input  5  destination register; in_reg_write, in_mem_read, in_mem_write  input  1 each  control bits.
REQ-009 SHALL have ports: out_valid  output  1  memory-stage entry valid; out_ready  input  1  memory stage consumes.
REQ-010 SHALL have ports: out_result, out_store_data  output  XLEN; out_rd  output  5; out_reg_write, out_mem_read, out_mem_write  output  1 each.

Function
REQ-011 SHALL hold two entries: main (drives out_*) and skid (overflow), each with its own valid bit.
REQ-012 SHALL implement states EMPTY (no valid), ONE (main valid only), FULL (main and skid valid).
REQ-013 SHALL drive in_ready = 1 in EMPTY and ONE, 0 in FULL, from registered state only (no combinational path from out_ready).
REQ-014 SHALL define accept = in_valid & in_ready and consume = out_valid & out_ready.
REQ-015 EMPTY: accept -> load main, go ONE; else stay.
REQ-016 ONE: accept & consume -> load main with input, stay ONE; accept & !consume -> load skid, go FULL; !accept & consume -> go EMPTY; else stay.
REQ-017 FULL: consume -> move skid to main, go ONE; else stay, all data held stable.
REQ-018 SHALL keep output data and out_valid unchanged while out_valid & !out_ready.
REQ-019 SHALL preserve order: entries leave in arrival order; no entry duplicated or dropped.
REQ-020 Latency: accepted entry SHALL appear on out_* the cycle after acceptance when buffer was EMPTY or consumed that cycle.
REQ-021 flush SHALL clear both valid bits next edge and go EMPTY, overriding any accept or consume that cycle; data registers need not clear.
REQ-022 Throughput SHALL be one entry per cycle while out_ready stays 1.
REQ-023 out_* control bits SHALL be forced 0 whenever out_valid = 0.

Reset
REQ-024 rst_n low SHALL immediately (asynchronously) set state EMPTY, out_valid 0, in_ready 1, all out_* data and control 0.
REQ-025 Reset asserted mid-transfer SHALL discard both entries; first cycle after release SHALL behave as EMPTY.

Configuration
REQ-026 Macro EX_MEM_FWD_BYPASS_EN defined: SHALL add outputs fwd_valid (1), fwd_rd (5), fwd_result (XLEN), combinationally equal to out_valid & out_reg_write & (out_rd != 0), out_rd, out_result.
REQ-027 Macro EX_MEM_FWD_BYPASS_EN undefined: fwd_* ports SHALL be absent; all other behaviour identical.

Verification
REQ-028 Reset, then single push result=0x0000_00F0 rd=5 with out_ready=1 -> out_valid=1 next cycle with out_result=0x0000_00F0, out_rd=5; EMPTY after consume.
REQ-029 out_ready=0, push A=0x1, B=0x2 back to back -> in_ready=0 after B, out_result=0x1 stable; third push stalled; raise out_ready -> 0x1 then 0x2 on consecutive cycles.
REQ-030 Stream 8 results 0x10..0x17 with out_ready=1 and in_valid=1 every cycle -> one output per cycle, order 0x10..0x17, in_ready always 1.
REQ-031 FULL state, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed input not captured.
REQ-032 Drop rst_n asynchronously between edges while FULL -> out_valid=0 and in_ready=1 before next edge; no stale entry after release.
REQ-033 With EX_MEM_FWD_BYPASS_EN, entry rd=0 reg_write=1 -> fwd_valid=0; rd=7 reg_write=1 result=0xDEAD_BEEF -> fwd_valid=1, fwd_rd=7, fwd_result=0xDEAD_BEEF.
